mul_add_acc: RTL and testbench
==============================

# mul_add_acc

N-channel signed/unsigned multiply-accumulate engine, the parametrised successor to the two-pair `Mul_Add` core. Each cycle it takes NCH operand pairs and a per-channel add/subtract mask, and reduces them to one beat sum. It then accumulates beat sums across a packet delimited by `in_last` and emits the packet result with a valid pulse. It sits in the audio datapath behind the sample buffers, where it serves FIR taps, mixers and gain/dot-product stages.

## Interface
Parameters:
- ASIZE, 16, width of each a operand (2..27)
- BSIZE, 16, width of each b operand (2..27)
- A_SIGNED, 1, 1 = a operands two's complement, 0 = unsigned
- B_SIGNED, 1, 1 = b operands two's complement, 0 = unsigned
- NCH, 4, operand pairs per beat (1..16)
- ACC_SIZE, 40, accumulator/output width; must be ≥ ASIZE+BSIZE+$clog2(NCH)+1 (elaboration error otherwise)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; when low, every register holds
- in_valid  in  1  beat qualifier
- in_last  in  1  last beat of packet; ignored unless in_valid
- a  in  NCH*ASIZE  channel i at bits [i*ASIZE +: ASIZE]
- b  in  NCH*BSIZE  channel i at bits [i*BSIZE +: BSIZE]
- sub  in  NCH  sub[i]=1 subtracts product i, 0 adds
- out_valid  out  1  one-cycle pulse per packet result
- out_p  out  ACC_SIZE  signed packet result
- out_ovf  out  1  packet overflowed ACC_SIZE (valid with out_valid)

## Operation
- Product i = ext(a_i)·ext(b_i), where ext sign- or zero-extends per A_SIGNED/B_SIGNED. Products are always treated as signed, with one guard bit for unsigned operands.
- Beat sum = Σ (sub[i] ? −prod_i : +prod_i), computed exactly in ASIZE+BSIZE+$clog2(NCH)+1 bits, then sign-extended to ACC_SIZE+1.
- Accumulator state uses a `first` flag, set on reset and after each last beat:
  - Beat with first=1: acc ← beat sum.
  - Beat with first=0: acc ← acc + beat sum.
  - Beat with in_last=1: result is registered to out_p, out_valid pulses, first←1.
- Beats with in_valid=0 are bubbles: no accumulator change, and first is unchanged.
- Single-beat packet (first beat also last): out_p = beat sum.
- Back-to-back packets are allowed. A new packet's first beat may immediately follow the previous last beat; it loads the accumulator rather than adding.
- Overflow: detected when the ACC_SIZE+1-bit add result is not representable in ACC_SIZE bits. out_ovf is sticky for the packet and clears when the next packet starts.
- Reset mid-packet discards the partial packet. No output is produced for it.
- Reset values: out_valid=0, out_p=0, out_ovf=0, acc=0, first=1, all pipeline valids 0.

## Timing
- Stage 1: products and a copy of valid/last/sub are registered on the edge that samples the beat (edge k).
- Stage 2: adder tree output is registered at edge k+1.
- Stage 3: accumulator, out_p, out_valid and out_ovf are registered at edge k+2. Latency is 3 ce-enabled edges from the last beat to out_valid.
- Throughput is one beat per cycle, with no backpressure.
- ce low freezes all stages, including out_valid. The consumer qualifies out_valid with ce.
- out_p holds its last result between pulses.

## Configuration
- MUL_ADD_ACC_SAT_EN defined: on overflow, acc clamps to +2^(ACC_SIZE−1)−1 or −2^(ACC_SIZE−1) per overflow direction. The clamped value continues accumulating.
- Not defined: acc wraps modulo 2^ACC_SIZE.
- out_ovf is reported identically in both builds.

## Structure
- Package mul_add_acc_pkg holds:
  - function to compute the beat-sum width;
  - function to compute the minimum ACC_SIZE;
  - saturation limit constants as functions of ACC_SIZE.
- Sub-module mul_add_tree covers stages 1–2: NCH multipliers, per-channel negate and the registered adder tree, with valid/last passed alongside.
- The top level holds the accumulator, first flag, overflow/saturation logic and output registers.

## Test plan
Defaults apply (NCH=4, 16×16 signed, ACC_SIZE=40) unless stated.
- Reset: hold rst for 5 cycles with random inputs and in_valid=1 -> out_valid=0, out_p=0, out_ovf=0 throughout.
- Single beat: a={4,3,2,1}, b={8,7,6,5} (ch3..ch0), sub=0, last=1 -> out_p=70 and out_valid high for exactly one cycle, 3 edges later.
- Subtract mask: same operands, sub=4'b1010 -> out_p=5−12+21−32=−18.
- Multi-beat with bubbles and ce stalls: 3 beats of all a=b=−32768, sub=0, with one bubble and 2 ce-low cycles inserted -> a single out_p=0x3_0000_0000 with out_ovf=0. A following packet starting immediately reports only its own sum.
- Overflow (ACC_SIZE=35): 4 beats of all a=b=−32768 -> out_ovf=1. With MUL_ADD_ACC_SAT_EN, out_p=0x3_FFFF_FFFF; without it, out_p=−2^34.
- Reset mid-packet: 2 beats, then an rst pulse, then a single-beat packet a={0,0,0,3}, b={0,0,0,3} -> exactly one out_valid, with out_p=9.

Source files
------------

// File: rtl/mul_add_acc_pkg.sv
// rtl/mul_add_acc_pkg.sv - width helpers and saturation limits for mul_add_acc
package mul_add_acc_pkg;

  localparam int MAX_ACC_SIZE = 64;

  // Exact width of one beat sum: full product, signed guard bit, log2(NCH) growth.
  function automatic int beat_width(input int asize, input int bsize, input int nch);
    return asize + bsize + $clog2(nch) + 1;
  endfunction

  function automatic int min_acc_size(input int asize, input int bsize, input int nch);
    return beat_width(asize, bsize, nch);
  endfunction

  function automatic logic [MAX_ACC_SIZE-1:0] sat_pos(input int acc_size);
    return (64'd1 << (acc_size - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_ACC_SIZE-1:0] sat_neg(input int acc_size);
    return ~sat_pos(acc_size);
  endfunction

endpackage

// File: rtl/mul_add_tree.sv
// rtl/mul_add_tree.sv - NCH multipliers (stage 1) and signed add/sub reduction (stage 2)
module mul_add_tree
  import mul_add_acc_pkg::*;
#(
  parameter int ASIZE    = 16,
  parameter int BSIZE    = 16,
  parameter int A_SIGNED = 1,
  parameter int B_SIGNED = 1,
  parameter int NCH      = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         ce,
  input  logic                                         in_valid,
  input  logic                                         in_last,
  input  logic [NCH*ASIZE-1:0]                         a,
  input  logic [NCH*BSIZE-1:0]                         b,
  input  logic [NCH-1:0]                               sub,
  output logic                                         tree_valid,
  output logic                                         tree_last,
  output logic signed [beat_width(ASIZE, BSIZE, NCH)-1:0] tree_sum
);

  localparam int PW = ASIZE + BSIZE + 1;
  localparam int BW = beat_width(ASIZE, BSIZE, NCH);

  // The true product always fits PW signed bits, so a PW x PW truncated multiply is exact.
  function automatic logic signed [PW-1:0] ext_mul(input logic [ASIZE-1:0] av,
                                                    input logic [BSIZE-1:0] bv);
    logic signed [PW-1:0] ax;
    logic signed [PW-1:0] bx;
    ax = (A_SIGNED != 0) ? PW'($signed(av)) : PW'(av);
    bx = (B_SIGNED != 0) ? PW'($signed(bv)) : PW'(bv);
    return ax * bx;
  endfunction

  logic signed [PW-1:0] prod_d [NCH];
  logic signed [PW-1:0] prod_q [NCH];
  logic [NCH-1:0]       sub_q;
  logic                 valid1_q;
  logic                 last1_q;
  logic signed [BW-1:0] sum_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      prod_d[i] = ext_mul(a[i*ASIZE +: ASIZE], b[i*BSIZE +: BSIZE]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;
      last1_q  <= 1'b0;
      sub_q    <= '0;
      for (int i = 0; i < NCH; i++) prod_q[i] <= '0;
    end else if (ce) begin
      valid1_q <= in_valid;
      last1_q  <= in_valid & in_last;
      sub_q    <= sub;
      for (int i = 0; i < NCH; i++) prod_q[i] <= prod_d[i];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sub_q[i]) sum_d = sum_d - BW'(prod_q[i]);
      else          sum_d = sum_d + BW'(prod_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_valid <= 1'b0;
      tree_last  <= 1'b0;
      tree_sum   <= '0;
    end else if (ce) begin
      tree_valid <= valid1_q;
      tree_last  <= last1_q;
      tree_sum   <= sum_d;
    end
  end

endmodule

// File: rtl/mul_add_acc.sv
// rtl/mul_add_acc.sv - N-channel multiply-accumulate with packet accumulation
// Optional MUL_ADD_ACC_SAT_EN: clamp accumulator on overflow instead of wrapping.
module mul_add_acc
  import mul_add_acc_pkg::*;
#(
  parameter int ASIZE    = 16,
  parameter int BSIZE    = 16,
  parameter int A_SIGNED = 1,
  parameter int B_SIGNED = 1,
  parameter int NCH      = 4,
  parameter int ACC_SIZE = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [NCH*ASIZE-1:0]       a,
  input  logic [NCH*BSIZE-1:0]       b,
  input  logic [NCH-1:0]             sub,
  output logic                       out_valid,
  output logic signed [ACC_SIZE-1:0] out_p,
  output logic                       out_ovf
);

  localparam int BW = beat_width(ASIZE, BSIZE, NCH);
  localparam int AW = ACC_SIZE + 1;
  localparam logic [ACC_SIZE-1:0] SAT_POS = ACC_SIZE'(sat_pos(ACC_SIZE));
  localparam logic [ACC_SIZE-1:0] SAT_NEG = ACC_SIZE'(sat_neg(ACC_SIZE));

  if (ACC_SIZE < min_acc_size(ASIZE, BSIZE, NCH) || ACC_SIZE > MAX_ACC_SIZE) begin : g_bad_acc_size
    $error("mul_add_acc: ACC_SIZE out of range for ASIZE/BSIZE/NCH");
  end

  logic                       tree_valid;
  logic                       tree_last;
  logic signed [BW-1:0]       tree_sum;
  logic signed [ACC_SIZE-1:0] acc_q;
  logic signed [ACC_SIZE-1:0] acc_d;
  logic                       first_q;
  logic                       ovf_q;
  logic                       ovf_d;
  logic                       ovf_now;
  logic signed [AW-1:0]       sum_w;

  mul_add_tree #(
    .ASIZE   (ASIZE),
    .BSIZE   (BSIZE),
    .A_SIGNED(A_SIGNED),
    .B_SIGNED(B_SIGNED),
    .NCH     (NCH)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .tree_valid(tree_valid),
    .tree_last (tree_last),
    .tree_sum  (tree_sum)
  );

  // A first beat loads rather than adds, so it can never overflow.
  always_comb begin
    sum_w   = (first_q ? '0 : AW'(acc_q)) + AW'(tree_sum);
    ovf_now = sum_w[AW-1] ^ sum_w[AW-2];
    ovf_d   = ovf_now | (~first_q & ovf_q);
    acc_d   = sum_w[ACC_SIZE-1:0];
`ifdef MUL_ADD_ACC_SAT_EN
    if (ovf_now) acc_d = sum_w[AW-1] ? SAT_NEG : SAT_POS;
    else         acc_d = sum_w[ACC_SIZE-1:0];
`else
    acc_d   = sum_w[ACC_SIZE-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      first_q   <= 1'b1;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_ovf   <= 1'b0;
    end else if (ce) begin
      out_valid <= tree_valid & tree_last;
      if (tree_valid) begin
        acc_q   <= acc_d;
        ovf_q   <= ovf_d;
        first_q <= tree_last;
        if (tree_last) begin
          out_p   <= acc_d;
          out_ovf <= ovf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_add_acc.sv
// tb/tb_mul_add_acc.sv - scoreboard bench for mul_add_acc at ACC_SIZE 40 and 35
module tb_mul_add_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [3:0] sub = '0;
  logic out_valid, out_ovf, out_valid_n, out_ovf_n;
  logic signed [39:0] out_p;
  logic signed [34:0] out_p_n;

  int n_tests = 0;
  int n_fail = 0;
  int ce_edges = 0;

  typedef struct {
    longint p40;
    bit     o40;
    longint p35;
    bit     o35;
    int     edge_no;
  } exp_t;
  exp_t exp_q[$];

  longint acc40 = 0, acc35 = 0;
  bit ovf40 = 1'b0, ovf35 = 1'b0, first_m = 1'b1;

  localparam logic [63:0] MINV = {4{16'h8000}};

  mul_add_acc dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_p(out_p), .out_ovf(out_ovf)
  );

  mul_add_acc #(.ACC_SIZE(35)) dut_n (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_n), .out_p(out_p_n), .out_ovf(out_ovf_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ce) ce_edges <= ce_edges + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] c3, input logic [15:0] c2,
                                        input logic [15:0] c1, input logic [15:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  function automatic longint beat_sum(input logic [63:0] av, input logic [63:0] bv,
                                      input logic [3:0] sv);
    longint s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      logic signed [15:0] ai;
      logic signed [15:0] bi;
      longint p;
      ai = av[i*16 +: 16];
      bi = bv[i*16 +: 16];
      p = longint'(ai) * longint'(bi);
      s = sv[i] ? s - p : s + p;
    end
    return s;
  endfunction

  task automatic acc_step(input longint bs, input int w, inout longint acc, inout bit ovf);
    longint mx, mn, s;
    bit o;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    s = (first_m ? 64'sd0 : acc) + bs;
    o = (s > mx) || (s < mn);
`ifdef MUL_ADD_ACC_SAT_EN
    if (o) s = (s > mx) ? mx : mn;
`else
    if (o) s = (s <<< (64 - w)) >>> (64 - w);
`endif
    acc = s;
    ovf = first_m ? o : (ovf | o);
  endtask

  task automatic step(input bit v, input bit l, input logic [63:0] av, input logic [63:0] bv,
                      input logic [3:0] sv, input bit c);
    int e0;
    longint bs;
    exp_t e;
    in_valid = v; in_last = l; a = av; b = bv; sub = sv; ce = c;
    e0 = ce_edges;
    @(posedge clk);
    if (c && v && !rst) begin
      bs = beat_sum(av, bv, sv);
      acc_step(bs, 40, acc40, ovf40);
      acc_step(bs, 35, acc35, ovf35);
      if (l) begin
        e.p40 = acc40; e.o40 = ovf40; e.p35 = acc35; e.o35 = ovf35; e.edge_no = e0;
        exp_q.push_back(e);
      end
      first_m = l;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 64'd0, 4'd0, 1'b1);
  endtask

  task automatic beat(input bit l, input logic [63:0] av, input logic [63:0] bv, input logic [3:0] sv);
    step(1'b1, l, av, bv, sv, 1'b1);
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!rst && ce && (out_valid || out_valid_n)) begin
      check("valid40", 64'(out_valid), 64'd1);
      check("valid35", 64'(out_valid_n), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("p40", 64'(out_p), e.p40);
        check("ovf40", 64'(out_ovf), 64'(e.o40));
        check("p35", 64'(out_p_n), e.p35);
        check("ovf35", 64'(out_ovf_n), 64'(e.o35));
        check("latency", 64'(ce_edges - e.edge_no), 64'd3);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'($urandom), r64(), r64(), 4'($urandom), 1'b1);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_p", 64'(out_p), 64'd0);
      check("rst_ovf", 64'(out_ovf), 64'd0);
      check("rst_valid_n", 64'(out_valid_n), 64'd0);
    end
    rst = 1'b0;
    first_m = 1'b1;
    idle(2);

    beat(1'b1, pack4(16'd4, 16'd3, 16'd2, 16'd1), pack4(16'd8, 16'd7, 16'd6, 16'd5), 4'b0000);
    idle(6);
    check("hold_p70", 64'(out_p), 64'd70);

    beat(1'b1, pack4(16'd4, 16'd3, 16'd2, 16'd1), pack4(16'd8, 16'd7, 16'd6, 16'd5), 4'b1010);
    idle(6);
    check("hold_pm18", 64'(out_p), -64'sd18);

    // three max-magnitude beats with a bubble and ce stalls carrying garbage, then back-to-back packet
    beat(1'b0, MINV, MINV, 4'b0000);
    step(1'b0, 1'b1, r64(), r64(), 4'($urandom), 1'b1);
    step(1'b1, 1'b1, r64(), r64(), 4'($urandom), 1'b0);
    beat(1'b0, MINV, MINV, 4'b0000);
    step(1'b1, 1'b1, r64(), r64(), 4'($urandom), 1'b0);
    beat(1'b1, MINV, MINV, 4'b0000);
    beat(1'b1, pack4(16'd1, 16'd1, 16'd1, 16'd1), pack4(16'd2, 16'd2, 16'd2, 16'd2), 4'b0000);
    idle(6);
    check("hold_p8", 64'(out_p), 64'd8);

    // overflows the 35-bit instance, then keeps accumulating past the clamp/wrap point
    for (int i = 0; i < 3; i++) beat(1'b0, MINV, MINV, 4'b0000);
    beat(1'b1, MINV, MINV, 4'b0000);
    for (int i = 0; i < 5; i++) beat(1'b0, MINV, MINV, 4'b0000);
    beat(1'b1, MINV, MINV, 4'b1111);
    beat(1'b1, pack4(16'd4, 16'd3, 16'd2, 16'd1), pack4(16'd8, 16'd7, 16'd6, 16'd5), 4'b0000);
    idle(6);

    for (int p = 0; p < 15; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b1, r64(), r64(), 4'($urandom), 1'b1);
        if ($urandom_range(0, 3) == 0) step(1'b1, 1'b1, r64(), r64(), 4'($urandom), 1'b0);
        beat(k == nb - 1, r64(), r64(), 4'($urandom));
      end
    end
    idle(6);

    beat(1'b0, MINV, MINV, 4'b0000);
    beat(1'b0, MINV, MINV, 4'b0000);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    first_m = 1'b1;
    beat(1'b1, pack4(16'd0, 16'd0, 16'd0, 16'd3), pack4(16'd0, 16'd0, 16'd0, 16'd3), 4'b0000);
    idle(8);
    check("hold_p9", 64'(out_p), 64'd9);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
